// File: rtl/program_memory_pkg.sv
// program_memory_pkg: shared constants and state encoding for the loadable instruction store.
//   DEPTH            instruction words (full 8-bit pc range)
//   PAD_INSN_DEFAULT branch-to-self word returned beyond the loaded length
//   AW / LW          address width and length width (one extra bit so 256 fits)
package program_memory_pkg;
   localparam int DEPTH = 256;
   localparam logic [7:0] PAD_INSN_DEFAULT = 8'hC3;
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   typedef enum logic [1:0] {IDLE, LOAD, RUN} state_e;
endpackage

// File: rtl/program_memory_if.sv
// program_memory_if: fetch port, byte-stream load port and status between loader/core and memory.
//   pc/instruction                             core fetch (instruction is combinational)
//   load_start/load_valid/load_data/load_last  loader requests and beats
//   load_ready                                 memory accepts a beat this cycle
//   cpu_reset/prog_len/load_error              core reset, loaded length, sticky overrun flag
interface program_memory_if;
   import program_memory_pkg::*;
   logic [AW-1:0] pc;
   logic [7:0] instruction;
   logic load_start;
   logic load_valid;
   logic [7:0] load_data;
   logic load_last;
   logic load_ready;
   logic cpu_reset;
   logic [LW-1:0] prog_len;
   logic load_error;
   modport master (
      output pc, load_start, load_valid, load_data, load_last,
      input instruction, load_ready, cpu_reset, prog_len, load_error
   );
   modport slave (
      input pc, load_start, load_valid, load_data, load_last,
      output instruction, load_ready, cpu_reset, prog_len, load_error
   );
endinterface

// File: rtl/program_ram.sv
// program_ram: DEPTHx8 storage, one synchronous write port, one asynchronous read port, no reset.
//   clk_i            write clock
//   we_i/waddr_i/wdata_i  write port (rising edge)
//   raddr_i/rdata_o  combinational read port
module program_ram
   import program_memory_pkg::*;
(
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [7:0]    wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [7:0]    rdata_o
);
   logic [7:0] mem_q [DEPTH];
   always_ff @(posedge clk_i)
      if (we_i) mem_q[waddr_i] <= wdata_i;
   assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/program_memory.sv
// program_memory: loadable instruction store feeding the core's fetch port and gating its reset.
//   clk    core clock
//   reset  asynchronous active-high reset
//   bus    slave side of program_memory_if (fetch, load stream, status)
module program_memory
   import program_memory_pkg::*;
#(
   parameter logic [7:0] PAD_INSN = PAD_INSN_DEFAULT
) (
   input logic clk,
   input logic reset,
   program_memory_if.slave bus
);
   state_e state_q, state_d;
   logic [AW-1:0] wptr_q, wptr_d;
   logic [LW-1:0] len_q, len_d;
   logic err_q, err_d;
   logic cpu_reset_q;
   logic load_ready;
   logic we;
   logic [7:0] rdata;
   assign load_ready = state_q == LOAD;
   always_comb begin
      state_d = state_q;
      wptr_d = wptr_q;
      len_d = len_q;
      err_d = err_q;
      we = 1'b0;
      case (state_q)
         IDLE, RUN: if (bus.load_start) begin
            state_d = LOAD;
            wptr_d = '0;
            len_d = '0;
            err_d = 1'b0;
         end
         LOAD: if (bus.load_start) begin
            // restart wins over a beat in the same cycle
            wptr_d = '0;
            len_d = '0;
            err_d = 1'b0;
         end else if (bus.load_valid) begin
            we = 1'b1;
            wptr_d = wptr_q + AW'(1);
            len_d = LW'(wptr_q) + LW'(1);
            // last byte flagged, or the store is full
            state_d = (bus.load_last || wptr_q == AW'(DEPTH - 1)) ? RUN : LOAD;
         end
         default: state_d = IDLE;
      endcase
      // an unaccepted beat sets the flag even when load_start clears it
      if (bus.load_valid && !load_ready) err_d = 1'b1;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q <= IDLE;
         wptr_q <= '0;
         len_q <= '0;
         err_q <= 1'b0;
         cpu_reset_q <= 1'b1;
      end else begin
         state_q <= state_d;
         wptr_q <= wptr_d;
         len_q <= len_d;
         err_q <= err_d;
         cpu_reset_q <= state_d != RUN;
      end
   program_ram u_ram (
      .clk_i  (clk),
      .we_i   (we),
      .waddr_i(wptr_q),
      .wdata_i(bus.load_data),
      .raddr_i(bus.pc),
      .rdata_o(rdata)
   );
   // 9-bit compare so a 256-byte program makes every pc valid
   assign bus.instruction = {1'b0, bus.pc} < len_q ? rdata : PAD_INSN;
   assign bus.load_ready = load_ready;
   assign bus.cpu_reset = cpu_reset_q;
   assign bus.prog_len = len_q;
   assign bus.load_error = err_q;
endmodule

// File: doc/program_memory.md
# program_memory

Loadable instruction store that serves the 8-bit processor core's fetch port: it takes the core's `pc` and returns `instruction` combinationally. Before execution, a byte-stream load port fills it with a program. It also drives the core's reset so the core executes only after a complete program is in place. It sits between the board-level loader (switch/serial front end) and the core, in the core's clock domain.

## Interface
- `DEPTH`, 256: instruction words. Equals the full 8-bit `pc` range.
- `PAD_INSN`, 8'hC3: value returned for fetches at or beyond the loaded length. Opcode 2'b11 (branch) with imm = -1 gives branch-to-self, which halts the core.

- `clk`  in  1: core clock. Writes and state updates happen on the rising edge.
- `reset`  in  1: asynchronous, active-high.
- `pc`  in  8: fetch address from the core.
- `instruction`  out  8: fetched word, combinational from `pc`.
- `load_start`  in  1: single-cycle request to begin a new load.
- `load_valid`  in  1: `load_data` is valid this cycle.
- `load_data`  in  8: program byte.
- `load_last`  in  1: qualifies the final byte; sampled only on an accepted beat.
- `load_ready`  out  1: the block accepts a beat this cycle.
- `cpu_reset`  out  1: registered reset to the core; high holds the core.
- `prog_len`  out  9: number of bytes loaded, 0..256.
- `load_error`  out  1: sticky flag for a beat offered while `load_ready` is low.

## Operation
- Three states: IDLE, LOAD, RUN. Encoding lives in the package.
- **Reset (async):**
  - state = IDLE, `cpu_reset` = 1, `load_ready` = 0, `prog_len` = 0, `load_error` = 0, write pointer = 0.
  - RAM contents are retained but unreachable, because `prog_len` = 0.
- **IDLE:** `cpu_reset` = 1. `load_start` moves to LOAD and clears `prog_len`, the write pointer and `load_error`.
- **LOAD:**
  - `load_ready` = 1 and `cpu_reset` = 1.
  - An accepted beat is `load_valid` && `load_ready`. It writes `mem[wptr]` = `load_data`, increments `wptr`, and sets `prog_len` = `wptr` + 1.
  - The beat that ends the load moves the block to RUN. That is either `load_last` = 1 or `wptr` = `DEPTH`-1 (auto-terminate at 256 bytes).
  - `load_start` in LOAD restarts the load: `wptr` = 0, `prog_len` = 0. A beat in the same cycle is discarded.
- **RUN:**
  - `cpu_reset` = 0 and `load_ready` = 0.
  - `load_start` moves to LOAD and clears `prog_len`, `wptr` and `load_error`. `cpu_reset` returns to 1 on the next edge.
- **Fetch:** `instruction` = `mem[pc]` when `pc` < `prog_len`, else `PAD_INSN`. This applies in every state.
- **Error:** `load_valid` && !`load_ready` sets `load_error` to 1. It clears only on `load_start` or `reset`.
  - A `load_valid` in the same cycle as the IDLE/RUN `load_start` is not accepted and sets the flag; the clear from `load_start` does not override it.
- **Length arithmetic:** `prog_len` is 9-bit. The compare `pc` < `prog_len` is done in 9 bits, so `prog_len` = 256 makes every `pc` valid.

## Timing
- Fetch latency: 0 cycles, asynchronous read. The core updates `pc` on the falling edge and consumes `instruction` in the same cycle.
- Write latency: a byte accepted at edge N is visible on `instruction` after edge N.
- `cpu_reset` deasserts on the edge after the terminating beat. The core's first fetch is `pc` = 0.
- `load_ready` is a registered function of state; it never depends combinationally on `load_valid`.
- The handshake tolerates gaps: a cycle with `load_valid` low writes nothing and advances nothing.
- Reset mid-load takes effect immediately. Bytes already written stay in RAM but fetches return `PAD_INSN`.

## Structure
- Package `program_memory_pkg`:
  - the state enum (IDLE/LOAD/RUN);
  - `DEPTH` and the `PAD_INSN` default;
  - the address width `$clog2(DEPTH)` and the length width `$clog2(DEPTH)+1`.
- Sub-module `program_ram`: `DEPTH`x8, one synchronous write port and one asynchronous read port, with no reset on the storage.
- The top level holds the FSM, write pointer, length register, error flag and pad mux.

## Test plan
- **Reset:** assert `reset` with `pc` = 8'h00 → `cpu_reset` = 1, `load_ready` = 0, `prog_len` = 0, `load_error` = 0, `instruction` = 8'hC3.
- **Short load:** pulse `load_start`, then send bytes 8'h05, 8'h4A, 8'h91 with `load_last` on the third.
  - `prog_len` = 3 and `cpu_reset` = 0 one edge after the third beat.
  - `pc` = 1 → 8'h4A; `pc` = 2 → 8'h91; `pc` = 3 → 8'hC3.
- **Gapped stream:** send the same bytes with `load_valid` low on alternate cycles → identical memory image and `prog_len` = 3; nothing is written on gap cycles.
- **Full load:** send 256 bytes (value = index) with no `load_last` → auto-RUN after byte 255, `prog_len` = 256, `pc` = 8'hFF → 8'hFF. A further `load_valid` sets `load_error` = 1.
- **Reload from RUN:** pulse `load_start` → `cpu_reset` = 1 on the next edge, `prog_len` = 0, `instruction` = 8'hC3. Then load one byte 8'h7E with `load_last` → `pc` = 0 → 8'h7E, `pc` = 1 → 8'hC3.
- **Async reset mid-load:** assert `reset` after 2 of 4 beats, between edges → state IDLE and `cpu_reset` = 1 immediately; `pc` = 0 → 8'hC3. A later `load_valid` sets `load_error`.
